// File: rtl/sleepy_spi_pkg.sv
// Shared definitions for the SPI register-programming slave: FSM states,
// frame layout constants and the address range helper.
package sleepy_spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    DONE
  } spi_state_e;

  localparam int FRAME_BITS = 16;
  localparam int RW_BIT     = 15;
  localparam int ADDR_BITS  = 7;

  function automatic logic addr_in_range(input logic [ADDR_BITS-1:0] addr,
                                         input int                   num_regs);
    return 32'(addr) < num_regs;
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchroniser for one asynchronous SPI pad, with optional
// rise/fall strobes derived from the synchronised level and its previous value.
module spi_sync #(
  parameter bit RST_VAL = 1'b0,
  parameter bit EDGES   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

  generate
    if (EDGES) begin : g_edges
      logic prev_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          prev_q <= RST_VAL;
        end else begin
          prev_q <= sync_q;
        end
      end

      assign rise_o = sync_q & ~prev_q;
      assign fall_o = ~sync_q & prev_q;
    end else begin : g_no_edges
      assign rise_o = 1'b0;
      assign fall_o = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/spi_reg_slave.sv
// SPI mode-0 slave decoding 16-bit R/W frames into a small 8-bit register
// bank, with oversampled inputs and a read-back shifter on spi_miso.
module spi_reg_slave
  import sleepy_spi_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  spi_sclk,
  input  logic                  spi_mosi,
  input  logic                  spi_cs_n,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  output logic [NUM_REGS*8-1:0] regs_flat,
  output logic                  wr_strobe,
  output logic [ADDR_W-1:0]     wr_addr
);

  logic sclk_s, sclk_rise, sclk_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;
  logic cs_s, cs_rise_unused, cs_fall_unused;

  spi_sync #(.RST_VAL(1'b0), .EDGES(1'b1)) u_sync_sclk (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (spi_sclk),
    .q_o    (sclk_s),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  spi_sync #(.RST_VAL(1'b0), .EDGES(1'b0)) u_sync_mosi (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (spi_mosi),
    .q_o    (mosi_s),
    .rise_o (mosi_rise_unused),
    .fall_o (mosi_fall_unused)
  );

  spi_sync #(.RST_VAL(1'b1), .EDGES(1'b0)) u_sync_cs (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (spi_cs_n),
    .q_o    (cs_s),
    .rise_o (cs_rise_unused),
    .fall_o (cs_fall_unused)
  );

  spi_state_e            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  // Only 15 bits are stored: the 16th frame bit is the live synchronised mosi.
  logic [FRAME_BITS-2:0] in_sh_q, in_sh_d;
  logic [7:0]            out_sh_q, out_sh_d;
  logic                  rd_q, rd_d;
  logic                  wr_strobe_q, commit_d;
  logic [ADDR_W-1:0]     wr_addr_q;
  logic [7:0]            regs_q [NUM_REGS];
  logic [FRAME_BITS-1:0] frame;
  logic [7:0]            rd_byte;
  logic                  sclk_unused;

  assign sclk_unused = sclk_s;
  assign frame       = {in_sh_q, mosi_s};
  assign rd_byte     = addr_in_range(frame[ADDR_BITS-1:0], NUM_REGS) ?
                       regs_q[frame[ADDR_W-1:0]] : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      in_sh_q  <= '0;
      out_sh_q <= 8'h00;
      rd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      in_sh_q  <= in_sh_d;
      out_sh_q <= out_sh_d;
      rd_q     <= rd_d;
    end
  end

  // A deselect (or ena low) wins over any sclk edge seen in the same cycle,
  // so a cs_n rise coincident with the 16th edge never commits.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    in_sh_d  = in_sh_q;
    out_sh_d = out_sh_q;
    rd_d     = rd_q;
    commit_d = 1'b0;
    if (!ena || cs_s) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
      rd_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = CMD;
          cnt_d   = 4'd0;
          in_sh_d = '0;
        end
        CMD: begin
          if (sclk_rise) begin
            in_sh_d = frame[FRAME_BITS-2:0];
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              state_d = DATA;
              rd_d    = ~frame[RW_BIT-8];
              if (!frame[RW_BIT-8]) begin
                out_sh_d = rd_byte;
              end
            end
          end
        end
        DATA: begin
          if (sclk_rise) begin
            in_sh_d = frame[FRAME_BITS-2:0];
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
              state_d  = DONE;
              commit_d = frame[RW_BIT] &&
                         addr_in_range(frame[8 +: ADDR_BITS], NUM_REGS);
            end
          end else if (sclk_fall && rd_q && cnt_q >= 4'd9) begin
            out_sh_d = {out_sh_q[6:0], 1'b0};
          end
        end
        default: begin
          state_d = DONE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= 8'h00;
      end
      wr_addr_q   <= '0;
      wr_strobe_q <= 1'b0;
    end else begin
      wr_strobe_q <= commit_d;
      if (commit_d) begin
        regs_q[frame[8 +: ADDR_W]] <= frame[7:0];
        wr_addr_q                  <= frame[8 +: ADDR_W];
      end
    end
  end

  generate
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign regs_flat[g*8 +: 8] = regs_q[g];
    end
  endgenerate

  assign wr_strobe   = wr_strobe_q;
  assign wr_addr     = wr_addr_q;
  assign spi_miso_oe = (state_q == DATA) && rd_q;
  assign spi_miso    = spi_miso_oe & out_sh_q[7];

endmodule
